// File: rtl/wide_add_seq.sv
`default_nettype none
// ============================================================================
// Module   : wide_add_seq
// Purpose  : Multi-cycle wide adder. A WIDTH*WORDS-bit addition is done one
//            WIDTH-bit slice per cycle on a single shared carry-lookahead
//            adder (cla). The carry between slices is held in a register.
//            Optional subtract mode via macro WIDE_ADD_SEQ_SUB_EN.
// Ports    : clk       - clock, rising edge
//            rst_n     - asynchronous active-low reset
//            in_valid  - request valid        in_ready - request accepted
//            in_a/in_b - operands             in_cin   - request carry-in
//            in_sub    - subtract (only with WIDE_ADD_SEQ_SUB_EN)
//            out_valid - result valid         out_ready - consumer ready
//            out_sum   - registered sum       out_cout  - registered carry-out
// Revision : 1.0 - initial release
// ============================================================================

// Carry-lookahead adder: full lookahead inside each 4-bit group, groups
// chained. Each group owns its carry-in signal so no vector feeds itself.
module cla #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int c_groups = WIDTH / 4;

  for (genvar gi = 0; gi < c_groups; gi++) begin : g_grp
    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [4:1] w_c;
    logic       w_ci;

    if (gi == 0) begin : g_first
      assign w_ci = cin;
    end else begin : g_next
      assign w_ci = g_grp[gi-1].w_c[4];
    end

    assign w_g = a[gi*4 +: 4] & b[gi*4 +: 4];
    assign w_p = a[gi*4 +: 4] ^ b[gi*4 +: 4];

    assign w_c[1] = w_g[0] | (w_p[0] & w_ci);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_ci);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & w_ci);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_ci);

    assign sum[gi*4 +: 4] = w_p ^ {w_c[3:1], w_ci};
  end

  assign cout = g_grp[c_groups-1].w_c[4];
endmodule

module wide_add_seq #(
  parameter int WIDTH = 32,
  parameter int WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH*WORDS-1:0] in_a,
  input  logic [WIDTH*WORDS-1:0] in_b,
  input  logic                   in_cin,
`ifdef WIDE_ADD_SEQ_SUB_EN
  input  logic                   in_sub,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH*WORDS-1:0] out_sum,
  output logic                   out_cout
);
  localparam int                IDXW       = $clog2(WORDS);
  localparam logic [IDXW-1:0]   c_last_idx = IDXW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic                   w_accept;
  logic                   w_step;
  logic                   w_last;

  logic [WIDTH*WORDS-1:0] r_a;
  logic [WIDTH*WORDS-1:0] r_b;
  logic                   r_carry;
  logic [IDXW-1:0]        r_idx;
  logic [WIDTH*WORDS-1:0] r_sum;
  logic                   r_cout;
  logic                   r_in_ready;
  logic                   r_out_valid;

  logic [WIDTH*WORDS-1:0] w_b_eff;
  logic                   w_cin_eff;
  logic [WIDTH-1:0]       w_a_slc;
  logic [WIDTH-1:0]       w_b_slc;
  logic [WIDTH-1:0]       w_cla_sum;
  logic                   w_cla_cout;

  // Subtraction is a + ~b + 1: invert b and force the initial carry at the
  // handshake so the slice loop itself is identical for both modes.
`ifdef WIDE_ADD_SEQ_SUB_EN
  assign w_b_eff   = in_sub ? ~in_b : in_b;
  assign w_cin_eff = in_sub ? 1'b1 : in_cin;
`else
  assign w_b_eff   = in_b;
  assign w_cin_eff = in_cin;
`endif

  assign w_a_slc = r_a[int'(r_idx)*WIDTH +: WIDTH];
  assign w_b_slc = r_b[int'(r_idx)*WIDTH +: WIDTH];

  cla #(.WIDTH(WIDTH)) u_cla (
    .a    (w_a_slc),
    .b    (w_b_slc),
    .cin  (r_carry),
    .sum  (w_cla_sum),
    .cout (w_cla_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_step   = 1'b0;
    w_last   = (r_idx == c_last_idx);
    case (r_state)
      IDLE: begin
        // r_in_ready gates the first cycle after reset release
        if (in_valid && r_in_ready) begin
          w_accept = 1'b1;
          w_next   = RUN;
        end
      end
      RUN: begin
        w_step = 1'b1;
        if (w_last) begin
          w_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Handshake flags are registered from the next state so both are low
  // while reset is held and in_ready rises one edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a         <= '0;
      r_b         <= '0;
      r_carry     <= 1'b0;
      r_idx       <= '0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_in_ready  <= (w_next == IDLE);
      r_out_valid <= (w_next == DONE);
      if (w_accept) begin
        r_a     <= in_a;
        r_b     <= w_b_eff;
        r_carry <= w_cin_eff;
        r_idx   <= '0;
      end else if (w_step) begin
        r_sum[int'(r_idx)*WIDTH +: WIDTH] <= w_cla_sum;
        r_carry                           <= w_cla_cout;
        if (w_last) begin
          r_cout <= w_cla_cout;
          r_idx  <= '0;
        end else begin
          r_idx  <= r_idx + 1'b1;
        end
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_sum   = r_sum;
  assign out_cout  = r_cout;
endmodule
`default_nettype wire
